// File: rtl/spi_pkt_pkg.sv
// Shared types and constants for the SPI packet source.
package spi_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_READY = 2'd2
    } pkt_state_t;

    localparam int unsigned SPI_WORD_BITS = 32;
    localparam int unsigned MAX_WORDS     = 64;

endpackage

// File: rtl/spi_sync.sv
// Plain two-flop synchronizer for an asynchronous single-bit input.
module spi_sync (
    input  logic clk,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        meta_q <= async_i;
        sync_q <= meta_q;
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a registered edge detector.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic edge_o
);

    logic sync_s;
    logic prev_q;
    logic edge_q;

    spi_sync u_sync (
        .clk     (clk),
        .async_i (async_i),
        .sync_o  (sync_s)
    );

    // level_o is the post-edge level, so level_o & edge_o is a rise and
    // ~level_o & edge_o a fall; the history flop is left unreset so that a
    // reset never fabricates an edge from a held line.
    always_ff @(posedge clk) begin
        prev_q <= sync_s;
        if (rst) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= sync_s ^ prev_q;
        end
    end

    assign level_o = prev_q;
    assign edge_o  = edge_q;

endmodule

// File: rtl/spi_pkt_source.sv
// SPI mode-0 slave that assembles a packet of 32-bit words into a buffer
// and serves single-cycle-latency word reads to the DPR.
module spi_pkt_source
    import spi_pkt_pkg::*;
#(
    parameter int unsigned MAX_WORDS = spi_pkt_pkg::MAX_WORDS,
    parameter int unsigned PTR_W     = $clog2(MAX_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     pkt_avail,
    input  logic                     dpr_done,
    output logic [PTR_W:0]           region_begin,
    output logic [PTR_W:0]           region_end,
    input  logic                     r_en,
    input  logic [PTR_W-1:0]         ptr,
    output logic [SPI_WORD_BITS-1:0] data_load,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(SPI_WORD_BITS);
    localparam logic [CNT_W-1:0] WORDS_FULL = CNT_W'(MAX_WORDS);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(SPI_WORD_BITS - 1);

    logic sclk_lvl, sclk_edge, cs_lvl, cs_edge, mosi_s;
    logic sclk_rise, cs_rise, cs_fall;

    spi_sync_edge u_sclk (
        .clk     (clk),
        .rst     (rst),
        .async_i (spi_sclk),
        .level_o (sclk_lvl),
        .edge_o  (sclk_edge)
    );

    spi_sync_edge u_cs (
        .clk     (clk),
        .rst     (rst),
        .async_i (spi_cs_n),
        .level_o (cs_lvl),
        .edge_o  (cs_edge)
    );

    spi_sync u_mosi (
        .clk     (clk),
        .async_i (spi_mosi),
        .sync_o  (mosi_s)
    );

    assign sclk_rise = sclk_edge & sclk_lvl;
    assign cs_rise   = cs_edge & cs_lvl;
    assign cs_fall   = cs_edge & ~cs_lvl;

    pkt_state_t                     state_q, state_d;
    logic [BIT_W-1:0]               bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]               word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]               region_end_q, region_end_d;
    logic [SPI_WORD_BITS-1:0]       shift_q, shift_d;
    logic                           err_q, err_d;
    logic                           wr_en;
    logic [SPI_WORD_BITS-1:0]       wr_word;
    logic [MAX_WORDS-1:0][SPI_WORD_BITS-1:0] mem_q;
    logic [SPI_WORD_BITS-1:0]       data_q;
    logic                           done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            region_end_q <= '0;
            shift_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            region_end_q <= region_end_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        region_end_d = region_end_q;
        shift_d      = shift_q;
        err_d        = err_q;
        wr_en        = 1'b0;
        wr_word      = {shift_q[SPI_WORD_BITS-2:0], mosi_s};

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    bit_cnt_d    = '0;
                    word_cnt_d   = '0;
                    region_end_d = '0;
                    state_d      = ST_RECV;
                end
            end
            ST_RECV: begin
                // End of frame takes precedence over a coincident bit edge.
                if (cs_rise) begin
                    if (bit_cnt_q != '0) begin
                        err_d = 1'b1;
                    end
                    if (word_cnt_q != '0) begin
                        region_end_d = word_cnt_q;
                        state_d      = ST_READY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (sclk_rise) begin
                    shift_d   = wr_word;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        if (word_cnt_q == WORDS_FULL) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en      = 1'b1;
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_READY: begin
                if (dpr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_cnt_q[PTR_W-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= r_en;
            if (r_en) begin
                data_q <= ({1'b0, ptr} < region_end_q) ? mem_q[ptr] : '0;
            end
        end
    end

    assign pkt_avail    = (state_q == ST_READY);
    assign region_begin = '0;
    assign region_end   = region_end_q;
    assign data_load    = data_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_spi_pkt_source.sv
// Bench for spi_pkt_source: a 64-word and a 4-word instance share one SPI
// stream and read bus, and are checked against a word-list packet model.
module tb_spi_pkt_source;

    localparam int DB = 64;
    localparam int DS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        dpr_done = 1'b0;
    logic        r_en = 1'b0;
    logic [5:0]  ptr_b = '0;
    logic [1:0]  ptr_s = '0;

    logic        avail_b, avail_s, done_b, done_s, err_b, err_s;
    logic [6:0]  rb_b, re_b;
    logic [2:0]  rb_s, re_s;
    logic [31:0] dl_b, dl_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Packet model: what each instance should hold after the frames so far.
    logic [31:0] m_mem_b [DB];
    logic [31:0] m_mem_s [DS];
    int          m_re_b = 0;
    int          m_re_s = 0;
    bit          m_err_b = 1'b0;
    bit          m_err_s = 1'b0;
    bit          m_avail = 1'b0;
    logic [31:0] tx [DB];

    always #5 clk = ~clk;

    spi_pkt_source #(.MAX_WORDS(DB)) u_big (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (sclk),
        .spi_cs_n     (cs_n),
        .spi_mosi     (mosi),
        .pkt_avail    (avail_b),
        .dpr_done     (dpr_done),
        .region_begin (rb_b),
        .region_end   (re_b),
        .r_en         (r_en),
        .ptr          (ptr_b),
        .data_load    (dl_b),
        .done         (done_b),
        .err          (err_b)
    );

    spi_pkt_source #(.MAX_WORDS(DS)) u_small (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (sclk),
        .spi_cs_n     (cs_n),
        .spi_mosi     (mosi),
        .pkt_avail    (avail_s),
        .dpr_done     (dpr_done),
        .region_begin (rb_s),
        .region_end   (re_s),
        .r_en         (r_en),
        .ptr          (ptr_s),
        .data_load    (dl_s),
        .done         (done_s),
        .err          (err_s)
    );

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded 60000 cycles, required completion");
        $fatal(1, "watchdog");
    end

    // Mode 0: data set while sclk low, sampled on rise; 3-clk half periods.
    task automatic spi_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = w[31 - i];
            #30 sclk = 1'b1;
            #30 sclk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_re_b = 0; m_re_s = 0; m_err_b = 0; m_err_s = 0; m_avail = 0;
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic send_frame(input int n, input int extra);
        bit was_avail = m_avail;
        bit seen = 1'b0;
        cs_n = 1'b0;
        #60;
        for (int i = 0; i < n; i++) spi_bits(tx[i], 32);
        if (extra > 0) spi_bits($urandom, extra);
        #60 cs_n = 1'b1;
        if (!was_avail) begin
            m_re_b = 0; m_re_s = 0;
            for (int i = 0; i < n; i++) begin
                if (i < DB) m_mem_b[i] = tx[i]; else m_err_b = 1'b1;
                if (i < DS) m_mem_s[i] = tx[i]; else m_err_s = 1'b1;
            end
            if (extra != 0) begin m_err_b = 1'b1; m_err_s = 1'b1; end
            if (n > 0) begin
                m_re_b  = (n < DB) ? n : DB;
                m_re_s  = (n < DS) ? n : DS;
                m_avail = 1'b1;
            end
        end
        if (m_avail && !was_avail) begin
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (avail_b === 1'b1) begin seen = 1'b1; break; end
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL avail_timeout: pkt_avail=%b after 12 cycles, required 1", avail_b);
            end
            repeat (2) @(negedge clk);
        end else begin
            repeat (14) @(negedge clk);
        end
    endtask

    task automatic test_status(input string tag);
        n_checks++;
        if (avail_b !== m_avail || avail_s !== m_avail) begin
            n_fail++;
            $display("FAIL %s_avail: pkt_avail big=%b small=%b, required %b", tag, avail_b, avail_s, m_avail);
        end
        n_checks++;
        if (re_b !== 7'(m_re_b)) begin
            n_fail++;
            $display("FAIL %s_region_end64: got %0d, required %0d", tag, re_b, m_re_b);
        end
        n_checks++;
        if (re_s !== 3'(m_re_s)) begin
            n_fail++;
            $display("FAIL %s_region_end4: got %0d, required %0d", tag, re_s, m_re_s);
        end
        n_checks++;
        if (rb_b !== 7'd0 || rb_s !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_region_begin: big=%0d small=%0d, required 0", tag, rb_b, rb_s);
        end
        n_checks++;
        if (err_b !== m_err_b || err_s !== m_err_s) begin
            n_fail++;
            $display("FAIL %s_err: big=%b small=%b, required %b %b", tag, err_b, err_s, m_err_b, m_err_s);
        end
    endtask

    // Back-to-back reads, one r_en per cycle; the result of each is checked
    // on the cycle after it was issued.
    task automatic test_read_burst(input string tag, input int n, input bit sequential);
        int pb = 0;
        int prev_p = 0;
        logic [31:0] eb = '0;
        logic [31:0] es = '0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if (dl_b !== eb || done_b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_read64 ptr=%0d: data=%h done=%b, required %h done=1", tag, prev_p, dl_b, done_b, eb);
                end
                n_checks++;
                if (dl_s !== es || done_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_read4 ptr=%0d: data=%h done=%b, required %h done=1", tag, prev_p % DS, dl_s, done_s, es);
                end
            end
            if (k < n) begin
                pb     = sequential ? k : int'($urandom_range(0, DB - 1));
                ptr_b  = 6'(pb);
                ptr_s  = 2'(pb % DS);
                eb     = (pb < m_re_b) ? m_mem_b[pb] : 32'h0;
                es     = ((pb % DS) < m_re_s) ? m_mem_s[pb % DS] : 32'h0;
                prev_p = pb;
                r_en   = 1'b1;
            end else begin
                r_en = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (done_b !== 1'b0 || done_s !== 1'b0 || dl_b !== eb || dl_s !== es) begin
            n_fail++;
            $display("FAIL %s_idle_hold: done=%b/%b data=%h/%h, required 0/0 %h/%h", tag, done_b, done_s, dl_b, dl_s, eb, es);
        end
    endtask

    task automatic release_pkt(input string tag);
        @(negedge clk); dpr_done = 1'b1;
        @(negedge clk); dpr_done = 1'b0;
        m_avail = 1'b0;
        n_checks++;
        if (avail_b !== 1'b0 || avail_s !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: pkt_avail big=%b small=%b, required 0", tag, avail_b, avail_s);
        end
    endtask

    task automatic test_reset();
        test_status("reset");
        n_checks++;
        if (dl_b !== 32'h0 || dl_s !== 32'h0 || done_b !== 1'b0 || done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: data=%h/%h done=%b/%b, required 0", dl_b, dl_s, done_b, done_s);
        end
    endtask

    task automatic test_basic_packet();
        for (int i = 0; i < 25; i++) tx[i] = (i > 3) ? $urandom : 32'h0;
        tx[0] = 32'h0000_0005;
        tx[3] = 32'h0000_0015;
        send_frame(25, 0);
        test_status("basic");
        test_read_burst("basic_seq", 26, 1'b1);
        test_read_burst("basic_rnd", 16, 1'b0);
    endtask

    task automatic test_ignore_ready();
        for (int i = 0; i < 3; i++) tx[i] = $urandom;
        send_frame(3, 5);
        test_status("ignore");
        test_read_burst("ignore", 8, 1'b1);
    endtask

    task automatic test_release_with_read();
        logic [31:0] eb = m_mem_b[1];
        @(negedge clk);
        ptr_b = 6'd1; ptr_s = 2'd1; r_en = 1'b1; dpr_done = 1'b1;
        @(negedge clk);
        r_en = 1'b0; dpr_done = 1'b0; m_avail = 1'b0;
        n_checks++;
        if (dl_b !== eb || done_b !== 1'b1 || avail_b !== 1'b0 || avail_s !== 1'b0) begin
            n_fail++;
            $display("FAIL release_read: data=%h done=%b avail=%b/%b, required %h 1 0/0", dl_b, done_b, avail_b, avail_s, eb);
        end
        test_read_burst("idle_read", 4, 1'b0);
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 3; i++) tx[i] = $urandom;
        send_frame(3, 0);
        test_status("oor");
        test_read_burst("oor", 5, 1'b1);
        release_pkt("oor");
    endtask

    task automatic test_partial_word();
        for (int i = 0; i < 2; i++) tx[i] = $urandom;
        send_frame(2, 7);
        test_status("partial");
        test_read_burst("partial", 4, 1'b1);
        release_pkt("partial");
    endtask

    task automatic test_overflow();
        pulse_rst();
        for (int i = 0; i < 6; i++) tx[i] = $urandom;
        send_frame(6, 0);
        test_status("overflow");
        test_read_burst("overflow", 7, 1'b1);
        release_pkt("overflow");
    endtask

    task automatic test_mid_reset();
        cs_n = 1'b0;
        #60;
        for (int i = 0; i < 10; i++) spi_bits($urandom, 32);
        #100;
        pulse_rst();
        test_status("midrst_now");
        #60 cs_n = 1'b1;
        repeat (14) @(negedge clk);
        test_status("midrst_after");
        tx[0] = 32'hDEAD_BEEF;
        send_frame(1, 0);
        test_status("midrst_frame");
        test_read_burst("midrst", 2, 1'b1);
        release_pkt("midrst");
    endtask

    task automatic test_empty_frame();
        send_frame(0, 0);
        test_status("empty");
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_packet();
        test_ignore_ready();
        test_release_with_read();
        test_out_of_range();
        test_partial_word();
        test_overflow();
        test_mid_reset();
        test_empty_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
